// File: rtl/bus_src_mux_pkg.sv
// -----------------------------------------------------------------------------
// bus_src_mux_pkg
// Shared processor package: bus source index constants, arbitration FSM
// state type and the width of the grant tenure counter.
// -----------------------------------------------------------------------------
package bus_src_mux_pkg;

    // Bus source indices used by the processor datapath.
    localparam int RA = 0;
    localparam int RB = 1;
    localparam int RC = 2;
    localparam int R1 = 3;
    localparam int R2 = 4;
    localparam int R3 = 5;
    localparam int DR = 6;
    localparam int AC = 9;
    localparam int PC = 10;

    // Tenure counter width; covers HOLD_CYC up to 255.
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,   // no grant outstanding
        ST_OWN  = 1'b1    // grant held, tenure counter running
    } arb_state_t;

endpackage

// File: rtl/bus_src_mux_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search. Returns the first requester found when
// scanning upward from (i_last + 1) mod NUM_SRC, wrapping around so that
// i_last itself is the final candidate.
//
// Ports
//   i_req    [NUM_SRC-1:0]  request vector, one bit per source
//   i_last   [SEL_W-1:0]    index of the previous grant
//   o_next   [SEL_W-1:0]    selected source index (0 when none found)
//   o_found                 at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_SRC = 11,
    parameter int SEL_W   = 4
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [SEL_W-1:0]   i_last,
    output logic [SEL_W-1:0]   o_next,
    output logic               o_found
);

    logic [SEL_W-1:0] w_cand;

    // Scan from the farthest candidate back to the nearest, so the nearest
    // requester after i_last is the last one written and therefore wins.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        o_next  = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_cand = SEL_W'((int'(i_last) + k) % NUM_SRC);
            if (i_req[w_cand]) begin
                o_next  = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_src_mux.sv
// -----------------------------------------------------------------------------
// bus_src_mux
// Registered bus source multiplexer with two modes:
//   direct mode      (arb_en=0): sel/sel_valid choose the source; an
//                                out-of-range select sets a sticky sel_err.
//   arbitration mode (arb_en=1): round-robin grant over req with a tenure of
//                                HOLD_CYC cycles per grant.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   src_data  [NUM_SRC*WIDTH] flattened sources, source i at [i*WIDTH +: WIDTH]
//   arb_en                   mode select
//   sel_valid, sel           direct-mode select strobe and index
//   req       [NUM_SRC]      arbitration-mode requests
//   err_clr                  clears sel_err (an illegal select the same cycle wins)
//   data_out  [WIDTH]        registered bus value
//   out_valid                data_out was loaded this cycle from a legal source
//   grant     [SEL_W]        index of the source that drove data_out
//   sel_err                  sticky illegal-select flag
// -----------------------------------------------------------------------------
module bus_src_mux
    import bus_src_mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_SRC  = 11,
    parameter int SEL_W    = 4,
    parameter int HOLD_CYC = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic                     arb_en,
    input  logic                     sel_valid,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC-1:0]       req,
    input  logic                     err_clr,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         grant,
    output logic                     sel_err
);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_last;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SEL_W-1:0] r_grant;
    logic             r_err;

    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SEL_W-1:0] w_last_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_valid_nxt;
    logic [SEL_W-1:0] w_grant_nxt;
    logic             w_err_nxt;

    logic [WIDTH-1:0] w_src [NUM_SRC];
    logic [SEL_W-1:0] w_pick;
    logic             w_found;
    logic             w_tenure_end;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign w_src[gi] = src_data[gi*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_rr_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_next  (w_pick),
        .o_found (w_found)
    );

    // Rearbitrate from IDLE, or when the owner's tenure is spent or it drops
    // its request. r_last tracks r_grant while owning, so the search starts
    // just past the current owner and reaches it again only as a last resort.
    assign w_tenure_end = (r_state == ST_IDLE) || (r_cnt == '0) || !req[r_grant];

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_last_nxt  = r_last;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_grant_nxt = r_grant;
        w_err_nxt   = r_err & ~err_clr;

        if (!arb_en) begin
            // Direct mode keeps the FSM parked in IDLE with a cleared counter,
            // so a switch back to arbitration always starts a fresh search.
            if (sel_valid) begin
                if (int'(sel) < NUM_SRC) begin
                    w_data_nxt  = w_src[sel];
                    w_grant_nxt = sel;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
        end else if (!w_tenure_end) begin
            w_state_nxt = ST_OWN;
            w_cnt_nxt   = r_cnt - 1'b1;
            w_data_nxt  = w_src[r_grant];
            w_valid_nxt = 1'b1;
        end else if (w_found) begin
            w_state_nxt = ST_OWN;
            w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
            w_last_nxt  = w_pick;
            w_grant_nxt = w_pick;
            w_data_nxt  = w_src[w_pick];
            w_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= SEL_W'(NUM_SRC - 1);
            r_data  <= '0;
            r_valid <= 1'b0;
            r_grant <= '0;
            r_err   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_grant <= w_grant_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign grant     = r_grant;
    assign sel_err   = r_err;

endmodule

// File: tb/tb_bus_src_mux.sv
// -----------------------------------------------------------------------------
// tb_bus_src_mux
// Two instances share one stimulus: HOLD_CYC=3 and HOLD_CYC=4. A behavioural
// model per instance tracks owner / cycles used / last grant and is compared
// against the outputs on every falling edge; directed literal checks pin the
// model to hand-derived values.
// -----------------------------------------------------------------------------
module tb_bus_src_mux;

    localparam int WIDTH   = 16;
    localparam int NUM_SRC = 11;
    localparam int SEL_W   = 4;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [WIDTH-1:0]         src [NUM_SRC];
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic                     arb_en;
    logic                     sel_valid;
    logic [SEL_W-1:0]         sel;
    logic [NUM_SRC-1:0]       req;
    logic                     err_clr;

    logic [WIDTH-1:0] d3, d4;
    logic             v3, v4, e3, e4;
    logic [SEL_W-1:0] g3, g4;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    int exp3 [7] = '{1, 1, 1, 4, 4, 4, 1};
    int exp4 [7] = '{1, 1, 1, 1, 4, 4, 4};

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pack
        assign src_data[gi*WIDTH +: WIDTH] = src[gi];
    end

    bus_src_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .HOLD_CYC(3)) u_dut3 (
        .clk(clk), .reset(reset), .src_data(src_data), .arb_en(arb_en),
        .sel_valid(sel_valid), .sel(sel), .req(req), .err_clr(err_clr),
        .data_out(d3), .out_valid(v3), .grant(g3), .sel_err(e3)
    );

    bus_src_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .HOLD_CYC(4)) u_dut4 (
        .clk(clk), .reset(reset), .src_data(src_data), .arb_en(arb_en),
        .sel_valid(sel_valid), .sel(sel), .req(req), .err_clr(err_clr),
        .data_out(d4), .out_valid(v4), .grant(g4), .sel_err(e4)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int               owner;  // -1 when nobody owns the bus
        int               used;   // cycles the owner has driven the bus
        int               last;   // most recent arbitration winner
        logic [WIDTH-1:0] data;
        logic             valid;
        int               grant;
        logic             err;
    } mdl_t;

    mdl_t m3, m4;

    function automatic mdl_t model_reset();
        mdl_t n;
        n.owner = -1;
        n.used  = 0;
        n.last  = NUM_SRC - 1;
        n.data  = '0;
        n.valid = 1'b0;
        n.grant = 0;
        n.err   = 1'b0;
        return n;
    endfunction

    function automatic mdl_t model_step(mdl_t m, int hold);
        mdl_t n;
        int   c;
        n       = m;
        n.valid = 1'b0;
        n.err   = m.err && !err_clr;
        if (!arb_en) begin
            n.owner = -1;
            n.used  = 0;
            if (sel_valid) begin
                if (int'(sel) < NUM_SRC) begin
                    n.data  = src[sel];
                    n.grant = int'(sel);
                    n.valid = 1'b1;
                end else begin
                    n.err = 1'b1;
                end
            end
        end else if (m.owner >= 0 && req[m.owner] && m.used < hold) begin
            n.used  = m.used + 1;
            n.data  = src[m.owner];
            n.valid = 1'b1;
        end else begin
            n.owner = -1;
            n.used  = 0;
            for (int k = 1; k <= NUM_SRC; k++) begin
                c = (m.last + k) % NUM_SRC;
                if (n.owner < 0 && req[c]) n.owner = c;
            end
            if (n.owner >= 0) begin
                n.used  = 1;
                n.last  = n.owner;
                n.grant = n.owner;
                n.data  = src[n.owner];
                n.valid = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m3 <= model_reset();
            m4 <= model_reset();
        end else begin
            m3 <= model_step(m3, 3);
            m4 <= model_step(m4, 4);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("h3.data_out",  32'(d3), 32'(m3.data));
            check("h3.out_valid", 32'(v3), 32'(m3.valid));
            check("h3.grant",     32'(g3), m3.grant);
            check("h3.sel_err",   32'(e3), 32'(m3.err));
            check("h4.data_out",  32'(d4), 32'(m4.data));
            check("h4.out_valid", 32'(v4), 32'(m4.valid));
            check("h4.grant",     32'(g4), m4.grant);
            check("h4.sel_err",   32'(e4), 32'(m4.err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        arb_en    = 1'b0;
        sel_valid = 1'b0;
        sel       = '0;
        req       = '0;
        err_clr   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) src[i] = 16'(32'h1000 + i * 32'h0111);
        src[10] = 16'h00A5;

        // Reset state.
        #1 reset = 1'b1;
        #1;
        check("rst.data_out",  32'(d3), 32'h0);
        check("rst.out_valid", 32'(v3), 32'h0);
        check("rst.grant",     32'(g3), 32'h0);
        check("rst.sel_err",   32'(e3), 32'h0);
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Direct select of source 10, the highest legal index.
        sel_valid = 1'b1;
        sel       = 4'd10;
        tick();
        check("dir10.data_out",  32'(d3), 32'h00A5);
        check("dir10.grant",     32'(g3), 32'd10);
        check("dir10.out_valid", 32'(v3), 32'h1);

        sel = 4'd2;
        tick();
        check("dir2.data_out", 32'(d3), 32'h1222);
        check("dir2.grant",    32'(g3), 32'd2);

        // Strobe low: hold, no valid.
        sel_valid = 1'b0;
        tick();
        check("idle.out_valid", 32'(v3), 32'h0);
        check("idle.data_out",  32'(d3), 32'h1222);

        // Illegal select 12 sets sel_err; set beats a simultaneous clear.
        sel_valid = 1'b1;
        sel       = 4'd12;
        tick();
        check("ill12.out_valid", 32'(v3), 32'h0);
        check("ill12.data_out",  32'(d3), 32'h1222);
        check("ill12.sel_err",   32'(e3), 32'h1);
        err_clr = 1'b1;
        sel     = 4'd13;
        tick();
        check("clr_vs_set.sel_err", 32'(e3), 32'h1);
        sel_valid = 1'b0;
        tick();
        check("clr.sel_err", 32'(e3), 32'h0);
        err_clr = 1'b0;

        // sel == NUM_SRC is the first illegal index; flag is sticky afterwards.
        sel_valid = 1'b1;
        sel       = 4'd11;
        tick();
        check("ill11.sel_err",   32'(e3), 32'h1);
        check("ill11.out_valid", 32'(v3), 32'h0);
        sel = 4'd0;
        tick();
        check("dir0.data_out", 32'(d3), 32'h1000);
        check("dir0.sticky",   32'(e3), 32'h1);
        err_clr   = 1'b1;
        sel_valid = 1'b0;
        tick();
        err_clr = 1'b0;

        // Arbitration: sources 1 and 4 alternate by tenure; sel is ignored.
        arb_en    = 1'b1;
        sel_valid = 1'b1;
        sel       = 4'd12;
        req       = 11'b000_0001_0010;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("rr3.grant[%0d]", i), 32'(g3), exp3[i]);
            check($sformatf("rr4.grant[%0d]", i), 32'(g4), exp4[i]);
            if (i == 1) src[1] = 16'hBEEF;
            if (i == 2) check("rr3.live_data", 32'(d3), 32'hBEEF);
        end
        check("rr3.no_sel_err", 32'(e3), 32'h0);
        sel_valid = 1'b0;

        // Owner drops its request early: next requester is granted at once.
        req = '0;
        tick();
        check("drop_all.out_valid", 32'(v4), 32'h0);
        req = 11'b000_0000_0100;
        tick();
        req = '0;
        tick();
        req = 11'b000_0001_0010;
        tick();
        check("own4.grant", 32'(g4), 32'd4);
        req = 11'b000_0000_0010;
        tick();
        check("early.grant",     32'(g4), 32'd1);
        check("early.out_valid", 32'(v4), 32'h1);

        // Sole requester is regranted back-to-back across tenure ends.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("regrant.grant",     32'(g3), 32'd1);
            check("regrant.out_valid", 32'(v3), 32'h1);
        end

        // Reset in the 2nd cycle of a tenure aborts it immediately.
        req = '0;
        tick();
        req = 11'b000_0010_0000;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort.data_out",  32'(d3), 32'h0);
        check("abort.out_valid", 32'(v3), 32'h0);
        check("abort.grant",     32'(g3), 32'h0);
        check("abort.grant4",    32'(g4), 32'h0);
        tick();
        reset = 1'b0;
        req   = 11'b000_1000_0001;
        tick();
        check("post_rst.grant",     32'(g3), 32'd0);
        check("post_rst.out_valid", 32'(v3), 32'h1);
        check("post_rst.data_out",  32'(d3), 32'h1000);
        check("post_rst.grant4",    32'(g4), 32'd0);

        // Mode switch mid-tenure: direct select wins on the very next edge.
        req = 11'b000_0100_0000;
        tick();
        tick();
        arb_en    = 1'b0;
        sel_valid = 1'b1;
        sel       = 4'd3;
        tick();
        check("mode.grant",     32'(g3), 32'd3);
        check("mode.data_out",  32'(d3), 32'h1333);
        check("mode.out_valid", 32'(v3), 32'h1);

        // Back to arbitration: last grant (6) is retained, sel 14 is ignored.
        arb_en = 1'b1;
        sel    = 4'd14;
        tick();
        check("back.grant",   32'(g3), 32'd6);
        check("back.sel_err", 32'(e3), 32'h0);
        tick();
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_src_mux.md
BUS_SRC_MUX -- requirements
Module: bus_src_mux

Interface
REQ-001 Parameter WIDTH, default 16, sets the bit width of each source word and of data_out.
REQ-002 Parameter NUM_SRC, default 11, sets the number of bus sources (2..16).
REQ-003 Parameter SEL_W, default 4, sets the select/grant width; SHALL satisfy 2**SEL_W >= NUM_SRC.
REQ-004 Parameter HOLD_CYC, default 1, sets the grant tenure in cycles for arbitration mode (1..255).
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 src_data  input  NUM_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 arb_en  input  1  0 = direct-select mode, 1 = round-robin arbitration mode.
REQ-009 sel_valid  input  1  direct-mode select strobe.
REQ-010 sel  input  SEL_W  direct-mode source index.
REQ-011 req  input  NUM_SRC  arbitration-mode request vector, one bit per source.
REQ-012 err_clr  input  1  clears sel_err.
REQ-013 data_out  output  WIDTH  registered bus value.
REQ-014 out_valid  output  1  data_out was loaded this cycle from a legal source.
REQ-015 grant  output  SEL_W  index of the source that drove data_out.
REQ-016 sel_err  output  1  sticky illegal-select flag.

Function
REQ-017 All outputs SHALL be registered; latency from a sel or req sample to data_out is exactly 1 cycle.
REQ-018 Direct mode: with sel_valid=1 and sel<NUM_SRC, the next edge SHALL load data_out=src[sel], grant=sel, out_valid=1.
REQ-019 Direct mode: with sel_valid=0, data_out and grant SHALL hold and out_valid SHALL be 0.
REQ-020 Direct mode: with sel_valid=1 and sel>=NUM_SRC, data_out and grant SHALL hold, out_valid=0, and sel_err SHALL be set.
REQ-021 sel_err SHALL stay set until err_clr=1; if err_clr and a new illegal select occur in the same cycle, the set SHALL win.
REQ-022 Arbitration FSM states: IDLE (no grant), OWN (grant held, tenure counter running).
REQ-023 IDLE: if any req bit is 1, the FSM SHALL grant the first requester searching upward from (last_grant+1) mod NUM_SRC, go to OWN, and load the counter with HOLD_CYC-1.
REQ-024 OWN: each cycle SHALL load data_out from the live src[grant] with out_valid=1, then decrement the counter.
REQ-025 OWN: the grant SHALL end and rearbitration SHALL occur on the same edge when the counter reaches 0 or req[grant] drops. With no other requester, the current owner SHALL be regranted if it still requests; otherwise the FSM SHALL go to IDLE.
REQ-026 IDLE: data_out and grant SHALL hold and out_valid SHALL be 0.
REQ-027 Arbitration mode SHALL ignore sel, sel_valid and never set sel_err; direct mode SHALL ignore req.
REQ-028 A change of arb_en SHALL take effect on the next edge: the FSM returns to IDLE and the counter clears, while last_grant is retained.

Reset
REQ-029 While reset=1, outputs SHALL be data_out=0, out_valid=0, grant=0 and sel_err=0, with FSM=IDLE, counter=0 and last_grant=NUM_SRC-1, so the first search starts at source 0.
REQ-030 Reset asserted mid-tenure SHALL abort the grant immediately, with no completion cycle.

Structure
REQ-031 The shared processor package SHALL hold the source-index constants: RA=0, RB=1, RC=2, R1=3, R2=4, R3=5, DR=6, AC=9, PC=10.
REQ-032 The shared processor package SHALL hold the FSM state enumeration.
REQ-033 Round-robin search SHALL live in one sub-module, rr_pick, which is combinational and takes req and last_grant and returns the next index and a found bit.

Verification
REQ-034 Direct mode: after reset, sel_valid=1, sel=10, src[10]=16'h00A5 -> one cycle later data_out=16'h00A5, grant=10, out_valid=1.
REQ-035 Direct mode: sel=12, sel_valid=1 -> data_out holds, out_valid=0, sel_err=1. Then err_clr=1 together with sel=13 -> sel_err stays 1.
REQ-036 Arbitration mode: HOLD_CYC=3, req=11'b000_0001_0010 -> source 1 is granted for 3 cycles, then source 4 for 3 cycles, then source 1 again.
REQ-037 Arbitration mode: HOLD_CYC=4, source 4 owns and drops req after 1 cycle while req[1]=1 -> the next edge grants 1.
REQ-038 Arbitration mode: reset asserted during the 2nd cycle of a tenure -> outputs are 0 immediately; after release with req[0]=1, the first grant is 0.
REQ-039 arb_en toggles 1->0 mid-tenure with sel_valid=1, sel=3 -> the next edge gives grant=3 and data_out=src[3].
